// File: rtl/arcade_input_ctrl_pkg.sv
// Shared constants and types for the arcade player-input front end.
package arcade_input_pkg;

  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_FIRE   = 4;
  localparam int JB_START  = 5;
  localparam int JB_START2 = 6;
  localparam int JB_COIN   = 7;

  typedef enum logic [1:0] {IDLE, ASSERT, GAP} coin_st_t;

endpackage

// File: rtl/arcade_input_ctrl_autofire.sv
// Per-player autofire: passes fire straight through, or toggles it every
// AF_HALF frame ticks while the button is held and autofire is enabled.
module arcade_autofire #(
  parameter int AF_HALF = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic tick,
  input  logic fire_in,
  input  logic en,
  output logic fire_out
);

  if (AF_HALF < 1 || AF_HALF > 15) begin : g_param_check
    $error("arcade_autofire: AF_HALF must be 1..15");
  end

  localparam logic [3:0] HALF_LAST = 4'(AF_HALF - 1);

  logic       fire_d;
  logic       en_d;
  logic [3:0] phase;

  // A fresh press or a fresh enable restarts the phase with the output high.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fire_d   <= 1'b0;
      en_d     <= 1'b0;
      phase    <= 4'd0;
      fire_out <= 1'b0;
    end else begin
      fire_d <= fire_in;
      en_d   <= en;
      if (!fire_in) begin
        fire_out <= 1'b0;
        phase    <= 4'd0;
      end else if (!en || !fire_d || !en_d) begin
        fire_out <= 1'b1;
        phase    <= 4'd0;
      end else if (tick) begin
        if (phase == HALF_LAST) begin
          fire_out <= ~fire_out;
          phase    <= 4'd0;
        end else begin
          phase <= phase + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Player-input front end: joystick mapping, autofire, and a queued,
// frame-timed coin pulse generator feeding the arcade core.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int JOY_W       = 16,
  parameter int COIN_PULSE  = 3,
  parameter int COIN_GAP    = 3,
  parameter int AF_HALF     = 2,
  parameter int QUEUE_MAX   = 7
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         vblank,
  input  logic [NUM_PLAYERS*JOY_W-1:0] joy_in,
  input  logic                         shared,
  input  logic [NUM_PLAYERS-1:0]       af_en,
  output logic [NUM_PLAYERS-1:0]       left,
  output logic [NUM_PLAYERS-1:0]       right,
  output logic [NUM_PLAYERS-1:0]       fire,
  output logic [NUM_PLAYERS-1:0]       start,
  output logic                         coin,
  output logic                         coin_drop,
  output logic [3:0]                   credits_q
);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4 || JOY_W < 8 ||
      COIN_PULSE < 1 || COIN_PULSE > 15 || COIN_GAP < 1 || COIN_GAP > 15 ||
      AF_HALF < 1 || AF_HALF > 15 || QUEUE_MAX < 1 || QUEUE_MAX > 15) begin : g_param_check
    $error("arcade_input_ctrl: parameter out of range");
  end

  localparam logic [3:0] PULSE_LAST = 4'(COIN_PULSE - 1);
  localparam logic [3:0] GAP_LAST   = 4'(COIN_GAP - 1);
  localparam logic [3:0] Q_MAX      = 4'(QUEUE_MAX);

  logic [JOY_W-1:0]       joy_or;
  logic                   unused_joy;
  logic [NUM_PLAYERS-1:0] s_left, s_right, s_fire, s_start;
  logic                   vblank_d, coin_d, tick, req, deq;
  coin_st_t               state;
  logic [3:0]             frame_cnt;

  assign unused_joy = ^joy_or;

  always_comb begin
    joy_or = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) joy_or |= joy_in[p*JOY_W +: JOY_W];
  end

  // In shared mode player 1 starts from the start2 button of the merged word.
  always_comb begin
    s_left  = '0;
    s_right = '0;
    s_fire  = '0;
    s_start = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      s_left[p]  = shared ? joy_or[JB_LEFT]  : joy_in[p*JOY_W + JB_LEFT];
      s_right[p] = shared ? joy_or[JB_RIGHT] : joy_in[p*JOY_W + JB_RIGHT];
      s_fire[p]  = shared ? joy_or[JB_FIRE]  : joy_in[p*JOY_W + JB_FIRE];
      if (shared)
        s_start[p] = (p == 0) ? joy_or[JB_START] : (p == 1) ? joy_or[JB_START2] : 1'b0;
      else
        s_start[p] = joy_in[p*JOY_W + JB_START];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      left  <= '0;
      right <= '0;
      start <= '0;
    end else begin
      left  <= s_left & ~s_right;
      right <= s_right & ~s_left;
      start <= s_start;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_af
    arcade_autofire #(.AF_HALF(AF_HALF)) u_af (
      .clk_sys (clk_sys),
      .reset   (reset),
      .tick    (tick),
      .fire_in (s_fire[p]),
      .en      (af_en[p]),
      .fire_out(fire[p])
    );
  end

  // Tracking vblank through reset keeps a high vblank at release from looking like a tick.
  always_ff @(posedge clk_sys) vblank_d <= vblank;

  assign tick = vblank & ~vblank_d;
  assign req  = joy_or[JB_COIN] & ~coin_d;
  assign deq  = (state == IDLE) && (credits_q != 4'd0);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      frame_cnt <= 4'd0;
      coin      <= 1'b0;
      coin_drop <= 1'b0;
      credits_q <= 4'd0;
      coin_d    <= 1'b0;
    end else begin
      coin_d    <= joy_or[JB_COIN];
      coin_drop <= req && !deq && (credits_q == Q_MAX);
      if (req && !deq && (credits_q != Q_MAX))
        credits_q <= credits_q + 4'd1;
      else if (deq && !req)
        credits_q <= credits_q - 4'd1;
      case (state)
        IDLE: begin
          if (deq) begin
            coin      <= 1'b1;
            frame_cnt <= 4'd0;
            state     <= ASSERT;
          end
        end
        ASSERT: begin
          if (tick) begin
            if (frame_cnt == PULSE_LAST) begin
              coin      <= 1'b0;
              frame_cnt <= 4'd0;
              state     <= GAP;
            end else begin
              frame_cnt <= frame_cnt + 4'd1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (frame_cnt == GAP_LAST) begin
              frame_cnt <= 4'd0;
              state     <= IDLE;
            end else begin
              frame_cnt <= frame_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl: mapping, autofire, coin queue and pulse timing.
module tb_arcade_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vblank;
  logic [31:0] joy_in;
  logic        shared;
  logic [1:0]  af_en;
  logic [1:0]  left, right, fire, start;
  logic        coin, coin_drop;
  logic [3:0]  credits_q;

  int   checks = 0;
  int   errors = 0;
  logic vb_run = 1'b0;
  int   vb_cnt = 50;
  logic vb_seen = 1'b0;
  logic last_tick = 1'b0;
  logic coin_prev = 1'b0;
  logic got;
  int   pulses, drops, width_bad, gap_bad, high_ticks, low_ticks, last_high;
  logic seen_fall;

  arcade_input_ctrl #(
    .NUM_PLAYERS(2), .JOY_W(16), .COIN_PULSE(3), .COIN_GAP(3), .AF_HALF(2), .QUEUE_MAX(7)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .vblank   (vblank),
    .joy_in   (joy_in),
    .shared   (shared),
    .af_en    (af_en),
    .left     (left),
    .right    (right),
    .fire     (fire),
    .start    (start),
    .coin     (coin),
    .coin_drop(coin_drop),
    .credits_q(credits_q)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] j0, input logic [15:0] j1,
                               input logic sh, input logic [1:0] af);
    joy_in = {j1, j0};
    shared = sh;
    af_en  = af;
  endtask

  task automatic clearStats();
    pulses = 0; drops = 0; width_bad = 0; gap_bad = 0;
    high_ticks = 0; low_ticks = 0; last_high = 0; seen_fall = 1'b0;
  endtask

  // One clock: the tick the DUT sees at this edge is predicted from the driven vblank.
  task automatic step();
    logic t;
    t = vblank & ~vb_seen;
    vb_seen = vblank;
    @(posedge clk_sys);
    #1;
    last_tick = t;
    if (coin_prev && t) high_ticks++;
    if (!coin_prev && t) low_ticks++;
    if (coin && !coin_prev) begin
      pulses++;
      if (seen_fall && low_ticks < 3) gap_bad++;
      high_ticks = 0;
    end
    if (!coin && coin_prev) begin
      if (high_ticks != 3) width_bad++;
      last_high = high_ticks;
      seen_fall = 1'b1;
      low_ticks = 0;
    end
    if (coin_drop) drops++;
    coin_prev = coin;
    if (vb_run) begin
      vb_cnt = (vb_cnt + 1) % 100;
      vblank = (vb_cnt < 10);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic waitTick(input int maxc);
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      step();
      if (last_tick) got = 1'b1;
    end
    checkOutput("tick_wait", {31'd0, got}, 32'd1);
  endtask

  task automatic coinEdge();
    joy_in[7] = 1'b1;
    step();
    joy_in[7] = 1'b0;
    step();
  endtask

  initial begin
    reset  = 1'b1;
    vblank = 1'b0;
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 2'b00);
    clearStats();

    $display("[TB] reset with all inputs high");
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("reset_outputs", {19'd0, left, right, fire, start, coin, coin_drop, credits_q}, 32'd0);
    end
    reset = 1'b0;
    step();
    checkOutput("post_reset_left", {30'd0, left}, 32'd0);
    checkOutput("post_reset_right", {30'd0, right}, 32'd0);
    checkOutput("post_reset_start", {30'd0, start}, 32'h3);
    checkOutput("post_reset_fire", {30'd0, fire}, 32'h3);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 2'b00);
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    step();

    $display("[TB] joystick mapping");
    applyStimulus(16'h0001, 16'h0002, 1'b1, 2'b00);
    step();
    checkOutput("shared_left", {30'd0, left}, 32'd0);
    checkOutput("shared_right", {30'd0, right}, 32'd0);
    applyStimulus(16'h0001, 16'h0002, 1'b0, 2'b00);
    step();
    checkOutput("sep_left", {30'd0, left}, 32'h2);
    checkOutput("sep_right", {30'd0, right}, 32'h1);
    checkOutput("sep_start_fire", {28'd0, start, fire}, 32'd0);
    applyStimulus(16'h0020, 16'h0040, 1'b1, 2'b00);
    step();
    checkOutput("shared_start_both", {30'd0, start}, 32'h3);
    applyStimulus(16'h0040, 16'h0000, 1'b1, 2'b00);
    step();
    checkOutput("shared_start2_only", {30'd0, start}, 32'h2);
    applyStimulus(16'h0040, 16'h0000, 1'b0, 2'b00);
    step();
    checkOutput("sep_start2_ignored", {30'd0, start}, 32'd0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 2'b00);
    step();

    $display("[TB] autofire");
    vb_run = 1'b1;
    waitTick(200);
    steps(3);
    applyStimulus(16'h0010, 16'h0010, 1'b0, 2'b01);
    step();
    checkOutput("af_press", {30'd0, fire}, 32'h3);
    for (int k = 1; k <= 10; k++) begin
      waitTick(200);
      checkOutput("af_phase", {31'd0, fire[0]}, ((k / 2) % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("af_off_player", {31'd0, fire[1]}, 32'd1);
    end
    applyStimulus(16'h0010, 16'h0010, 1'b0, 2'b00);
    step();
    checkOutput("af_disable_mid", {30'd0, fire}, 32'h3);
    applyStimulus(16'h0010, 16'h0010, 1'b0, 2'b01);
    step();
    checkOutput("af_reenable_high", {31'd0, fire[0]}, 32'd1);
    waitTick(200);
    checkOutput("af_reenable_t1", {31'd0, fire[0]}, 32'd1);
    waitTick(200);
    checkOutput("af_reenable_t2", {31'd0, fire[0]}, 32'd0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 2'b01);
    step();
    checkOutput("af_release", {30'd0, fire}, 32'd0);

    $display("[TB] single coin");
    clearStats();
    joy_in[7] = 1'b1;
    step();
    checkOutput("coin_queued", {28'd0, credits_q}, 32'd1);
    checkOutput("coin_not_yet", {31'd0, coin}, 32'd0);
    joy_in[7] = 1'b0;
    step();
    checkOutput("coin_dequeued", {28'd0, credits_q}, 32'd0);
    checkOutput("coin_high", {31'd0, coin}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      step();
      if (!coin) got = 1'b1;
    end
    checkOutput("coin_fall_wait", {31'd0, got}, 32'd1);
    checkOutput("coin_high_ticks", last_high, 32'd3);
    steps(600);
    checkOutput("coin_single_pulse", pulses, 32'd1);

    $display("[TB] coin queue saturation");
    clearStats();
    for (int i = 0; i < 9; i++) coinEdge();
    checkOutput("queue_saturated", {28'd0, credits_q}, 32'd7);
    checkOutput("drop_count", drops, 32'd1);
    checkOutput("drop_one_cycle", {31'd0, coin_drop}, 32'd0);
    steps(5500);
    checkOutput("queue_pulses", pulses, 32'd8);
    checkOutput("queue_width_bad", width_bad, 32'd0);
    checkOutput("queue_gap_bad", gap_bad, 32'd0);
    checkOutput("queue_drained", {28'd0, credits_q}, 32'd0);

    $display("[TB] reset mid-pulse");
    clearStats();
    for (int i = 0; i < 5; i++) coinEdge();
    checkOutput("mid_credits", {28'd0, credits_q}, 32'd4);
    checkOutput("mid_coin", {31'd0, coin}, 32'd1);
    reset = 1'b1;
    step();
    checkOutput("mid_reset_coin", {31'd0, coin}, 32'd0);
    checkOutput("mid_reset_credits", {28'd0, credits_q}, 32'd0);
    reset = 1'b0;
    clearStats();
    steps(500);
    checkOutput("after_reset_quiet", pulses, 32'd0);
    coinEdge();
    checkOutput("after_reset_new_coin", {31'd0, coin}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
